// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants and types. The pipeline registers use the
// bubble constant when they are flushed or reset.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_t;

    typedef struct packed {
        stat_t       stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } ereg_t;

    localparam ereg_t EREG_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valC:  64'h0,
        valA:  64'h0,
        valB:  64'h0,
        dstE:  R_NONE,
        dstM:  R_NONE,
        srcA:  R_NONE,
        srcB:  R_NONE
    };

endpackage

// File: rtl/dreg_ids.sv
// Decode-stage register ID and operand selection from the D-register fields.
module dreg_ids
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valP,
    input  logic [63:0] rvalA,
    input  logic [63:0] rvalB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB
);

    always_comb begin
        srcA = R_NONE;
        srcB = R_NONE;
        dstE = R_NONE;
        dstM = R_NONE;
        case (icode)
            I_RRMOVQ: begin srcA = rA; dstE = rB; end
            I_IRMOVQ: dstE = rB;
            I_RMMOVQ: begin srcA = rA; srcB = rB; end
            I_MRMOVQ: begin srcB = rB; dstM = rA; end
            I_OPQ:    begin srcA = rA; srcB = rB; dstE = rB; end
            I_CALL:   begin srcB = R_RSP; dstE = R_RSP; end
            I_RET:    begin srcA = R_RSP; srcB = R_RSP; dstE = R_RSP; end
            I_PUSHQ:  begin srcA = rA; srcB = R_RSP; dstE = R_RSP; end
            I_POPQ:   begin srcA = R_RSP; srcB = R_RSP; dstE = R_RSP; dstM = rA; end
            default: ;
        endcase
    end

    // CALL and JXX carry the fall-through PC down the pipe in valA.
    assign valA = (icode == I_CALL || icode == I_JXX) ? valP : rvalA;
    assign valB = rvalB;

endmodule

// File: rtl/rexecute_ctl.sv
// Decode-to-execute boundary: E pipeline register plus load/use, mispredict
// and ret hazard controls for the F and D registers.
module rexecute_ctl
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [63:0] d_rvalA,
    input  logic [63:0] d_rvalB,
    input  logic        e_Cnd,
    input  logic [3:0]  M_icode,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  d_dstE,
    output logic [3:0]  d_dstM,
    output logic [1:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble
);

    ereg_t       e_q;
    ereg_t       e_d;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic        load_use;
    logic        mispredict;
    logic        ret_pend;
    logic        e_bubble;

    dreg_ids u_ids (
        .icode (D_icode),
        .rA    (D_rA),
        .rB    (D_rB),
        .valP  (D_valP),
        .rvalA (d_rvalA),
        .rvalB (d_rvalB),
        .srcA  (d_srcA),
        .srcB  (d_srcB),
        .dstE  (d_dstE),
        .dstM  (d_dstM),
        .valA  (d_valA),
        .valB  (d_valB)
    );

    // RNONE guard keeps unused source slots from matching an absent load target.
    assign load_use   = (e_q.icode == I_MRMOVQ || e_q.icode == I_POPQ) &&
                        (e_q.dstM != R_NONE) &&
                        (e_q.dstM == d_srcA || e_q.dstM == d_srcB);
    assign mispredict = (e_q.icode == I_JXX) && !e_Cnd;
    assign ret_pend   = (D_icode == I_RET) || (e_q.icode == I_RET) || (M_icode == I_RET);

    assign F_stall  = load_use | ret_pend;
    assign D_stall  = load_use;
    assign D_bubble = mispredict | (ret_pend & ~load_use);
    assign e_bubble = mispredict | load_use;

    always_comb begin
        e_d       = EREG_BUBBLE;
        if (!e_bubble) begin
            e_d.stat  = stat_t'(D_stat);
            e_d.icode = D_icode;
            e_d.ifun  = D_ifun;
            e_d.valC  = D_valC;
            e_d.valA  = d_valA;
            e_d.valB  = d_valB;
            e_d.dstE  = d_dstE;
            e_d.dstM  = d_dstM;
            e_d.srcA  = d_srcA;
            e_d.srcB  = d_srcB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= EREG_BUBBLE;
        else        e_q <= e_d;
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valC;
    assign E_valA  = e_q.valA;
    assign E_valB  = e_q.valB;
    assign E_dstE  = e_q.dstE;
    assign E_dstM  = e_q.dstM;
    assign E_srcA  = e_q.srcA;
    assign E_srcB  = e_q.srcB;

endmodule

// File: doc/rexecute_ctl.md
# rexecute_ctl

Decode-to-execute boundary of the Y86-64 pipeline: it consumes the D-register fields produced by the fetch/decode pipeline register and derives source/destination register IDs for the register file. It latches the execute-stage (E) register and generates the pipeline hazard controls (F_stall, D_stall, D_bubble, E bubble) for load/use, mispredicted jumps and `ret`. Sits between the decode-stage register-file/forwarding logic and the execute stage.

## Interface
- No parameters; widths fixed by the ISA (stat 2, icode/ifun/reg 4, data 64).
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- D_stat, D_icode, D_ifun, D_rA, D_rB  in  2/4/4/4/4  D-register fields
- D_valC, D_valP  in  64  D-register constant / next PC
- d_rvalA, d_rvalB  in  64  forwarded operand values for d_srcA / d_srcB
- e_Cnd  in  1  condition result of instruction currently in E
- M_icode  in  4  icode in M register (ret detection)
- d_srcA, d_srcB, d_dstE, d_dstM  out  4  decode register IDs (combinational)
- E_stat, E_icode, E_ifun  out  2/4/4  E register
- E_valC, E_valA, E_valB  out  64  E register
- E_dstE, E_dstM, E_srcA, E_srcB  out  4  E register
- F_stall, D_stall, D_bubble  out  1  hazard controls to F and D registers (combinational)

## Operation
- Encodings: HALT 0, NOP 1, RRMOVQ/CMOV 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B; RSP 4, RNONE F; stat AOK 00, HLT 01, ADR 10, INS 11.
- d_srcA: rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ; RSP for POPQ, RET; else RNONE.
- d_srcB: rB for OPQ, RMMOVQ, MRMOVQ; RSP for PUSHQ, POPQ, CALL, RET; else RNONE.
- d_dstE: rB for RRMOVQ, IRMOVQ, OPQ; RSP for PUSHQ, POPQ, CALL, RET; else RNONE. Cmov suppression is done in execute, not here.
- d_dstM: rA for MRMOVQ, POPQ; else RNONE.
- d_valA: D_valP for CALL, JXX; else d_rvalA. d_valB = d_rvalB.
- load_use = E_icode in {MRMOVQ, POPQ} and E_dstM != RNONE and E_dstM in {d_srcA, d_srcB}.
- mispredict = E_icode == JXX and !e_Cnd.
- ret_pend = RET in any of D_icode, E_icode, M_icode.
- F_stall = load_use | ret_pend.
- D_stall = load_use.
- D_bubble = mispredict | (ret_pend & !load_use) (the D-stage RET compare uses D_icode).
- E_bubble (internal) = mispredict | load_use.
- Bubble value: stat AOK, icode NOP, ifun 0, valC/valA/valB 0, all register IDs RNONE.
- E register: on a clock edge, loads the bubble value if E_bubble, else {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB}. E is never stalled.

## Timing
- Reset (rst_n low, asynchronous): E register = bubble value immediately; outputs E_* bubble regardless of clk. Control outputs then follow inputs combinationally (with E_icode = NOP, F_stall/D_stall/D_bubble depend only on D_icode/M_icode).
- Release is synchronous to the next rising edge; the first capture happens on the first edge with rst_n high.
- Latency: D fields to E_* = 1 cycle. Hazard outputs are valid in the same cycle as their inputs and are not registered.
- load_use and mispredict together: E bubbles, D stalls, and D_bubble also asserts. The D register must give stall priority (hold).
- rA/rB of RNONE never match load_use, because of the explicit RNONE guard.

## Structure
- Shared package `y86_pkg`: icode/stat/register constants, bubble-value constants and the stat typedef, reused by all pipeline registers.
- One sub-module is natural: `dreg_ids`, the combinational srcA/srcB/dstE/dstM/valA selection. Hazard logic and the E register stay in the top.

## Test plan
- Reset mid-run: assert rst_n low with E holding OPQ. E_icode becomes 1 and E_dstE becomes F immediately, without a clock edge.
- OPQ rA=2 rB=3, d_rvalA=5, d_rvalB=7. The next edge gives E_icode=6, E_valA=5, E_valB=7, E_srcA=2, E_dstE=3, and no stall.
- MRMOVQ rA=1 in E, then OPQ rA=1 in D. F_stall=D_stall=1, and E becomes the bubble at the next edge. After that edge the stall clears.
- JXX in E with e_Cnd=0. D_bubble=1 and no F_stall, and E loads the bubble at the next edge. With e_Cnd=1 there is no bubble.
- RET in D: F_stall=1 and D_bubble=1 while RET occupies D, E and M (3 cycles). With M_icode=0 and nothing in D/E, both deassert.
- CALL with D_valP=0x40: E_valA=0x40, E_srcB=E_dstE=4, E_dstM=F.
